// File: rtl/mux16_scan_pkg.sv
// Shared definitions for the 16:1 strobed-mux scan sequencer.
//   NCH     : number of mux channels
//   SELW    : width of the channel select code {D,C,B,A}
//   state_t : sequencer states
package mux16_scan_pkg;

    localparam int NCH  = 16;
    localparam int SELW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mux16_next_ch.sv
// Combinational find-first-set used to pick the next channel to scan.
// Ports:
//   mask  in  NCH   enabled channels
//   ch    in  SELW  current channel; only channels above it are candidates
//   first in  1     1 = ignore ch and search the whole mask (the "ch = -1" case)
//   found out 1     a candidate channel exists
//   idx   out SELW  lowest candidate channel (0 when found = 0)
module mux16_next_ch
    import mux16_scan_pkg::*;
(
    input  logic [NCH-1:0]  mask,
    input  logic [SELW-1:0] ch,
    input  logic            first,
    output logic            found,
    output logic [SELW-1:0] idx
);

    logic [NCH:0]   upto_ch;
    logic [NCH-1:0] cand;

    // NOTE: every variable written here gets a default before any branch,
    // so no path can leave one unassigned and infer a latch.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        // Bits 0..ch set; one bit wider so ch = 15 does not overflow.
        upto_ch = ((NCH+1)'(2) << ch) - (NCH+1)'(1);
        cand    = first ? mask : (mask & ~upto_ch[NCH-1:0]);
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found = 1'b1;
                idx   = i[SELW-1:0];
            end
        end
    end

endmodule

// File: rtl/mux16_scan_ctrl.sv
// Scan sequencer for a 16:1 strobed mux with inverted output W.
// On start it visits every enabled channel in ascending order: drive sel,
// hold for SETTLE_CYC cycles with stb low, sample ~w for one cycle.
// The collected bits are published as a 16-bit snapshot with a done pulse.
// Parameters:
//   SETTLE_CYC : settle cycles per channel before sampling (1..15)
//   CONT       : 1 = start a fresh scan automatically after each done
// Ports:
//   clk     in   1   rising-edge clock
//   rst_n   in   1   synchronous active-low reset
//   start   in   1   scan request, honoured only in idle
//   mask    in   16  channel enable, latched at scan start
//   w       in   1   mux output, inverted data
//   sel     out  4   channel select {D,C,B,A}
//   stb     out  1   mux strobe, 1 = mux disabled
//   busy    out  1   scan in progress, including the done cycle
//   done    out  1   one-cycle pulse, data/changed refreshed this cycle
//   data    out  16  last completed snapshot, true polarity, masked bits 0
//   changed out  1   latest snapshot differs from the one before it
//   valid   out  1   at least one scan completed since reset
module mux16_scan_ctrl
    import mux16_scan_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter bit CONT       = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NCH-1:0]  mask,
    input  logic            w,
    output logic [SELW-1:0] sel,
    output logic            stb,
    output logic            busy,
    output logic            done,
    output logic [NCH-1:0]  data,
    output logic            changed,
    output logic            valid
);

    state_t          state_q, state_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NCH-1:0]  mask_q;
    logic [NCH-1:0]  shadow_q, shadow_d;
    logic            rescan_q;

    logic            go;
    logic            mask_load;
    logic            snap_load;

    logic            nc_first;
    logic [NCH-1:0]  nc_mask;
    logic            nc_found;
    logic [SELW-1:0] nc_idx;

    // In idle the search runs over the live mask (it is latched on the same
    // edge); during a scan it runs over the latched copy above the current ch.
    assign nc_first = (state_q == ST_IDLE);
    assign nc_mask  = nc_first ? mask : mask_q;

    mux16_next_ch u_next_ch (
        .mask  (nc_mask),
        .ch    (ch_q),
        .first (nc_first),
        .found (nc_found),
        .idx   (nc_idx)
    );

    // rescan_q is high only in the idle cycle that follows a done in
    // continuous mode, acting as an internal start request.
    assign go = start | rescan_q;

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        mask_load = 1'b0;
        snap_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    mask_load = 1'b1;
                    shadow_d  = '0;
                    cnt_d     = '0;
                    if (nc_found) begin
                        state_d = ST_SETTLE;
                        ch_d    = nc_idx;
                    end else begin
                        // Empty mask: publish an all-zero snapshot at once.
                        state_d   = ST_DONE;
                        snap_load = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'(SETTLE_CYC - 1)) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                shadow_d[ch_q] = ~w;
                cnt_d          = '0;
                if (nc_found) begin
                    state_d = ST_SETTLE;
                    ch_d    = nc_idx;
                end else begin
                    // Publish on entry to done so data is already current
                    // while the done pulse is high.
                    state_d   = ST_DONE;
                    snap_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel  = ch_q;
    assign stb  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            rescan_q <= 1'b0;
            data     <= '0;
            changed  <= 1'b0;
            valid    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            rescan_q <= CONT && (state_q == ST_DONE);
            if (mask_load) begin
                mask_q <= mask;
            end
            if (snap_load) begin
                data    <= shadow_d;
                changed <= (shadow_d != data);
                valid   <= 1'b1;
            end
        end
    end

    // NOTE: the shadow image is cleared at every scan start before any bit is
    // read, so it carries no reset; a reset mid-scan simply abandons it.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Self-checking bench for mux16_scan_ctrl: models the strobed mux and checks
// snapshots, latency and select sequences against a behavioural model.
module tb_mux16_scan_ctrl;

    localparam int SETTLE = 2;

    typedef struct {
        logic [15:0] m;
        logic [15:0] ev;
        logic [15:0] exp_data;
        int          exp_lat;
        logic        exp_changed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] mask = '0;
    logic [15:0] e = '0;

    logic        w, stb, busy, done, changed, valid;
    logic [3:0]  sel;
    logic [15:0] data;

    logic        w_c, stb_c, busy_c, done_c, changed_c, valid_c;
    logic [3:0]  sel_c;
    logic [15:0] data_c;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] model_data = '0;

    always #5 clk = ~clk;

    // Mux model: inverted data when enabled, forced high when strobed off.
    assign w   = stb   ? 1'b1 : ~e[sel];
    assign w_c = stb_c ? 1'b1 : ~e[sel_c];

    mux16_scan_ctrl #(.SETTLE_CYC(SETTLE), .CONT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .w(w),
        .sel(sel), .stb(stb), .busy(busy), .done(done), .data(data),
        .changed(changed), .valid(valid)
    );

    mux16_scan_ctrl #(.SETTLE_CYC(SETTLE), .CONT(1'b1)) u_cont (
        .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .w(w_c),
        .sel(sel_c), .stb(stb_c), .busy(busy_c), .done(done_c), .data(data_c),
        .changed(changed_c), .valid(valid_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Runs one scan from idle (called at a negedge). Returns DONE latency in
    // cycles after the start-sampling edge (0 = timed out), the snapshot and
    // whether the strobed select trace matched the mask order.
    task automatic do_scan(input logic [15:0] m, input logic [15:0] ev, input int pulse_at,
                           output int lat, output logic [15:0] d, output logic chg,
                           output logic vld, output logic sel_ok, output logic busy1);
        logic [3:0] seen[$];
        logic [3:0] want[$];
        lat = 0; d = '0; chg = 1'b0; vld = 1'b0; busy1 = 1'b0;
        e = ev; mask = m; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mask  = 16'($urandom);          // must not affect the running scan
        for (int cyc = 1; cyc <= 60; cyc++) begin
            start = (cyc == pulse_at);
            if (cyc == 1) busy1 = busy;
            if (!stb) seen.push_back(sel);
            if (done) begin
                lat = cyc; d = data; chg = changed; vld = valid;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        for (int c = 0; c < 16; c++)
            if (m[c]) for (int k = 0; k <= SETTLE; k++) want.push_back(4'(c));
        sel_ok = (seen.size() == want.size());
        if (sel_ok) foreach (want[i]) if (seen[i] != want[i]) sel_ok = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("busy_after_done", busy, 1'b0);
    endtask

    task automatic scan_and_check(input string name, input logic [15:0] m, input logic [15:0] ev,
                                  input int pulse_at);
        int lat; logic [15:0] d; logic chg, vld, sok, b1;
        logic [15:0] exp_d;
        exp_d = ev & m;
        do_scan(m, ev, pulse_at, lat, d, chg, vld, sok, b1);
        check({name, "_lat"}, lat, 1 + $countones(m) * (SETTLE + 1));
        check({name, "_data"}, d, exp_d);
        check({name, "_changed"}, chg, exp_d != model_data);
        check({name, "_valid"}, vld, 1'b1);
        check({name, "_sel_seq"}, sok, 1'b1);
        check({name, "_busy"}, b1, 1'b1);
        model_data = exp_d;
    endtask

    initial begin
        vec_t vt[5];
        int lat; logic [15:0] d; logic chg, vld, sok, b1;
        int extra;
        int t_done[$];
        logic [15:0] e_base;

        e_base = 16'hA5C3;
        vt[0] = '{16'hFFFF, e_base,               16'hA5C3, 49, 1'b1};
        vt[1] = '{16'hFFFF, e_base,               16'hA5C3, 49, 1'b0};
        vt[2] = '{16'hFFFF, e_base ^ 16'h0080,    16'hA543, 49, 1'b1};
        vt[3] = '{16'h8001, 16'hFFFF,             16'h8001,  7, 1'b1};
        vt[4] = '{16'h0000, 16'h1234,             16'h0000,  1, 1'b1};

        // Reset held three cycles.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_sel", sel, 4'd0);
        check("rst_stb", stb, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_data", data, 16'h0);
        check("rst_valid", valid, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);

        // Directed table.
        foreach (vt[i]) begin
            do_scan(vt[i].m, vt[i].ev, 0, lat, d, chg, vld, sok, b1);
            check($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
            check($sformatf("vec%0d_data", i), d, vt[i].exp_data);
            check($sformatf("vec%0d_changed", i), chg, vt[i].exp_changed);
            check($sformatf("vec%0d_valid", i), vld, 1'b1);
            check($sformatf("vec%0d_sel_seq", i), sok, 1'b1);
            model_data = vt[i].exp_data;
        end

        // Randomized scans against the model.
        for (int i = 0; i < 8; i++) begin
            logic [15:0] m;
            m = 16'($urandom);
            if (i == 2) m = 16'h0;
            if (i == 5) m = 16'h8000;
            scan_and_check($sformatf("rnd%0d", i), m, 16'($urandom), 0);
        end

        // Start pulse mid-scan is ignored: one DONE only, nothing queued.
        scan_and_check("mid_start", 16'hFFFF, 16'h3C5A, 10);
        extra = 0;
        for (int c = 0; c < 55; c++) begin
            if (done) extra++;
            @(negedge clk);
        end
        check("mid_start_no_extra_done", extra, 0);

        // Reset at cycle 20 of a full scan aborts it.
        e = 16'hFFFF; mask = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_stb", stb, 1'b1);
        check("abort_data", data, 16'h0);
        check("abort_valid", valid, 1'b0);
        rst_n = 1'b1;
        extra = 0;
        for (int c = 0; c < 60; c++) begin
            if (done) extra++;
            @(negedge clk);
        end
        check("abort_no_done", extra, 0);
        model_data = '0;

        // Continuous mode: one start, then DONE every 50 cycles.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e = 16'h0F0F; mask = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 200 && t_done.size() < 3; cyc++) begin
            if (done_c) t_done.push_back(cyc);
            @(negedge clk);
        end
        check("cont_pulses", t_done.size(), 3);
        if (t_done.size() == 3) begin
            check("cont_first", t_done[0], 49);
            check("cont_period1", t_done[1] - t_done[0], 50);
            check("cont_period2", t_done[2] - t_done[1], 50);
        end
        check("cont_data", data_c, 16'h0F0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
